// File: rtl/ram_arbiter.sv
// Two-port (instruction fetch / load-store) round-robin arbiter in front of a
// single-ported 64-bit memory helper; one transaction in flight at a time.
module ram_arbiter #(
    parameter logic [63:0]    BASE = 64'h0000_0000_8000_0000,
    localparam int unsigned   XLEN = 64,
    localparam int unsigned   ILEN = 32
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            if_req,
    input  logic [XLEN-1:0] if_addr,
    output logic            if_gnt,
    output logic            if_rvalid,
    output logic [ILEN-1:0] if_rdata,
    output logic            if_err,
    input  logic            if_rready,

    input  logic            ls_req,
    input  logic            ls_wen,
    input  logic [XLEN-1:0] ls_addr,
    input  logic [XLEN-1:0] ls_wdata,
    input  logic [XLEN-1:0] ls_wmask,
    output logic            ls_gnt,
    output logic            ls_rvalid,
    output logic [XLEN-1:0] ls_rdata,
    output logic            ls_err,
    input  logic            ls_rready,

    output logic            mem_en,
    output logic            mem_wen,
    output logic [XLEN-1:0] mem_idx,
    output logic [XLEN-1:0] mem_wdata,
    output logic [XLEN-1:0] mem_wmask,
    input  logic [XLEN-1:0] mem_rdata
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    logic [1:0]      state_q, state_d;
    logic            last_ls_q, last_ls_d;
    logic            owner_ls_q, owner_ls_d;
    logic            half_q, half_d;
    logic            wen_q, wen_d;
    logic            err_q, err_d;

    logic            mem_en_d, mem_wen_d;
    logic [XLEN-1:0] mem_idx_d, mem_wdata_d, mem_wmask_d;

    logic            if_rvalid_d, if_err_d;
    logic [ILEN-1:0] if_rdata_d;
    logic            ls_rvalid_d, ls_err_d;
    logic [XLEN-1:0] ls_rdata_d;

    logic            pick_ls;
    logic [XLEN-1:0] win_addr;
    logic [XLEN-1:0] win_off;
    logic            win_err;
    logic            win_wen;

    // Winner selection: a lone requester always wins, on contention the port not granted last.
    assign pick_ls  = ls_req && (!if_req || !last_ls_q);
    assign win_addr = pick_ls ? ls_addr : if_addr;
    assign win_wen  = pick_ls && ls_wen;
    assign win_err  = win_addr < BASE;
    assign win_off  = win_addr - BASE;

    always_comb begin
        state_d     = state_q;
        last_ls_d   = last_ls_q;
        owner_ls_d  = owner_ls_q;
        half_d      = half_q;
        wen_d       = wen_q;
        err_d       = err_q;
        if_gnt      = 1'b0;
        ls_gnt      = 1'b0;
        mem_en_d    = 1'b0;
        mem_wen_d   = 1'b0;
        mem_idx_d   = '0;
        mem_wdata_d = '0;
        mem_wmask_d = '0;
        if_rvalid_d = if_rvalid;
        if_rdata_d  = if_rdata;
        if_err_d    = if_err;
        ls_rvalid_d = ls_rvalid;
        ls_rdata_d  = ls_rdata;
        ls_err_d    = ls_err;

        case (state_q)
            IDLE: begin
                if (if_req || ls_req) begin
                    if_gnt     = !pick_ls;
                    ls_gnt     = pick_ls;
                    last_ls_d  = pick_ls;
                    owner_ls_d = pick_ls;
                    half_d     = win_addr[2];
                    wen_d      = win_wen;
                    err_d      = win_err;
                    // Memory strobes are registered so they are live for exactly the ACCESS cycle.
                    mem_en_d   = !win_err;
                    mem_wen_d  = !win_err && win_wen;
                    mem_idx_d  = win_off >> 3;
                    if (win_wen) begin
                        mem_wdata_d = ls_wdata;
                        mem_wmask_d = ls_wmask;
                    end
                    state_d    = ACCESS;
                end
            end
            ACCESS: begin
                state_d = RESP;
                if (owner_ls_q) begin
                    ls_rvalid_d = 1'b1;
                    ls_err_d    = err_q;
                    ls_rdata_d  = (err_q || wen_q) ? '0 : mem_rdata;
                end else begin
                    if_rvalid_d = 1'b1;
                    if_err_d    = err_q;
                    if_rdata_d  = err_q ? '0 : (half_q ? mem_rdata[63:32] : mem_rdata[31:0]);
                end
            end
            RESP: begin
                if (owner_ls_q ? ls_rready : if_rready) begin
                    state_d     = IDLE;
                    if_rvalid_d = 1'b0;
                    if_rdata_d  = '0;
                    if_err_d    = 1'b0;
                    ls_rvalid_d = 1'b0;
                    ls_rdata_d  = '0;
                    ls_err_d    = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            last_ls_q  <= 1'b0;
            owner_ls_q <= 1'b0;
            half_q     <= 1'b0;
            wen_q      <= 1'b0;
            err_q      <= 1'b0;
            mem_en     <= 1'b0;
            mem_wen    <= 1'b0;
            mem_idx    <= '0;
            mem_wdata  <= '0;
            mem_wmask  <= '0;
            if_rvalid  <= 1'b0;
            if_rdata   <= '0;
            if_err     <= 1'b0;
            ls_rvalid  <= 1'b0;
            ls_rdata   <= '0;
            ls_err     <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_ls_q  <= last_ls_d;
            owner_ls_q <= owner_ls_d;
            half_q     <= half_d;
            wen_q      <= wen_d;
            err_q      <= err_d;
            mem_en     <= mem_en_d;
            mem_wen    <= mem_wen_d;
            mem_idx    <= mem_idx_d;
            mem_wdata  <= mem_wdata_d;
            mem_wmask  <= mem_wmask_d;
            if_rvalid  <= if_rvalid_d;
            if_rdata   <= if_rdata_d;
            if_err     <= if_err_d;
            ls_rvalid  <= ls_rvalid_d;
            ls_rdata   <= ls_rdata_d;
            ls_err     <= ls_err_d;
        end
    end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter BASE, default 64'h0000_0000_8000_0000, physical address mapped to memory word index 0.
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 if_req  in  1  instruction-fetch request; held high until if_gnt.
REQ-005 if_addr  in  64  fetch byte address; bit 2 selects the 32-bit half.
REQ-006 if_gnt  out  1  fetch request accepted this cycle.
REQ-007 if_rvalid / if_rdata / if_err  out  1/32/1  fetch response: valid, instruction, address error.
REQ-008 if_rready  in  1  fetch requester accepts response.
REQ-009 ls_req / ls_wen  in  1/1  load-store request; ls_wen=1 means write.
REQ-010 ls_addr / ls_wdata / ls_wmask  in  64/64/64  byte address (bits 2:0 ignored), write data, bit-wise write mask.
REQ-011 ls_gnt  out  1  load-store request accepted this cycle.
REQ-012 ls_rvalid / ls_rdata / ls_err  out  1/64/1  load-store response; also acknowledges writes.
REQ-013 ls_rready  in  1  load-store requester accepts response.
REQ-014 mem_en / mem_wen  out  1/1  memory-helper read enable, write enable.
REQ-015 mem_idx / mem_wdata / mem_wmask  out  64/64/64  word index, write data, write mask to memory helper.
REQ-016 mem_rdata  in  64  combinational read data from memory helper for current mem_idx.

Function
REQ-017 The block SHALL implement a 3-state FSM: IDLE, ACCESS, RESP.
REQ-018 IDLE: if any req is high, the block SHALL assert exactly one gnt (combinational, same cycle), latch the winner's address/wen/wdata/wmask and owner ID, and go to ACCESS; otherwise it stays in IDLE.
REQ-019 Arbitration SHALL be round-robin: on contention the port not granted last wins; the last-grant register resets to "fetch" so the first contention goes to load-store.
REQ-020 Without contention the single requester SHALL be granted regardless of last-grant.
REQ-021 gnt SHALL never be asserted outside IDLE; req held during ACCESS/RESP is ignored until the next IDLE.
REQ-022 ACCESS (exactly one cycle): mem_idx SHALL equal (latched_addr - BASE) >> 3 (64-bit modular subtract, logical shift); mem_en=1 for reads, mem_wen=1 with mem_en=1 for writes; mem_rdata SHALL be captured into the response register; next state RESP.
REQ-023 Address error: if latched_addr < BASE, ACCESS SHALL keep mem_en=0 and mem_wen=0, the response SHALL have err=1 and rdata=0.
REQ-024 Fetch response data SHALL be mem_rdata[63:32] if latched_addr[2]=1, otherwise mem_rdata[31:0].
REQ-025 RESP: the owner's rvalid SHALL be held high with stable rdata/err until its rready is high; that cycle returns to IDLE; the non-owner's rvalid SHALL stay 0.
REQ-026 Write responses SHALL have rdata=0, err per REQ-023.
REQ-027 Outside ACCESS, mem_en, mem_wen SHALL be 0; mem_idx, mem_wdata, mem_wmask SHALL be 0.
REQ-028 Minimum access period SHALL be 3 cycles (gnt, ACCESS, RESP with immediate rready); a new gnt is possible in the cycle after RESP completes.
REQ-029 Exactly one memory write SHALL occur per granted write; none for reads or errored requests.

Reset
REQ-030 While rst is high at a clock edge, the FSM SHALL enter IDLE and last-grant SHALL be set to fetch; the response registers and latched request SHALL be cleared.
REQ-031 All outputs SHALL be 0 during and after reset until a new request arrives (gnt remains combinational in IDLE).
REQ-032 Reset in ACCESS or RESP SHALL abandon the transaction: no rvalid is produced, and no mem_wen is asserted after the reset edge.

Verification
REQ-033 Fetch only: if_addr=0x8000_0004, mem word0=0x1111_2222_3333_4444 -> if_gnt at cycle 0, mem_idx=0 at cycle 1, if_rvalid with if_rdata=0x1111_2222 at cycle 2.
REQ-034 Contention after reset: if_req and ls_req high together, repeated 3 times -> grants in order ls, if, ls.
REQ-035 Write: ls_wen=1, ls_addr=0x8000_0010, wmask=0xFF -> one-cycle mem_wen with mem_idx=2, ls_rvalid with ls_rdata=0, ls_err=0.
REQ-036 Backpressure: ls_rready low for 4 cycles -> ls_rvalid and ls_rdata stable for 5 cycles, if_req stays ungranted, if_gnt follows in the next IDLE.
REQ-037 Error: if_addr=0x7FFF_FFFC -> mem_en stays 0, if_rvalid with if_err=1 and if_rdata=0.
REQ-038 Reset in ACCESS during a write -> no rvalid, no further mem_wen, FSM back in IDLE, next contention granted to ls.
